// File: rtl/ram_access_arbiter.sv
// Purpose: round-robin arbiter and frame sequencer for two word-level requesters sharing one framed single-port sync RAM.
// Latency: gnt in cycle 1 after req is sampled in IDLE; write done in cycle 4; read done in cycle 5 (RAM answers in 1 cycle).
// Backpressure: requesters hold req until their done pulse; the losing port simply waits in IDLE arbitration.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   p0_* / p1_*               requester ports: req/we/addr/wdata in, gnt/done one-cycle pulses out
//   rdata, err                read result and timeout flag, valid with the done pulse
//   ram_din, ram_rx_valid     command frame to the RAM ({type[1:0], payload})
//   ram_dout, ram_tx_valid    read data returned by the RAM
module ram_access_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_SIZE-1:0] p0_addr,
    input  logic [7:0]           p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_done,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_SIZE-1:0] p1_addr,
    input  logic [7:0]           p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_done,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP,
        DATA,
        WAIT_RD,
        DONE
    } state_t;

    state_t               state;
    logic                 rr_ptr;     // port preferred when both request
    logic                 winner;     // port owning the current transaction
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [7:0]           wdata_q;
    logic [7:0]           rd_cnt;

    logic                 pick;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [7:0]           sel_wdata;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        pick      = 1'b0;
        if (p0_req && p1_req) begin
            pick = rr_ptr;
        end else begin
            pick = p1_req;
        end
        sel_we    = pick ? p1_we    : p0_we;
        sel_addr  = pick ? p1_addr  : p0_addr;
        sel_wdata = pick ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            winner       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 8'h00;
            rd_cnt       <= 8'h00;
            p0_gnt       <= 1'b0;
            p1_gnt       <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            rdata        <= 8'h00;
            err          <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            // Pulses default low; each state raises only what it owns.
            p0_gnt       <= 1'b0;
            p1_gnt       <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            ram_rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        // Request fields are frozen here until DONE.
                        winner       <= pick;
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        ram_rx_valid <= 1'b1;
                        ram_din      <= {(sel_we ? 2'b00 : 2'b10), sel_addr};
                        p0_gnt       <= ~pick;
                        p1_gnt       <= pick;
                        state        <= ADDR;
                    end
                end

                ADDR: begin
                    state <= GAP;
                end

                GAP: begin
                    ram_rx_valid <= 1'b1;
                    if (we_q) begin
                        ram_din <= {2'b01, ADDR_SIZE'(wdata_q)};
                    end else begin
                        ram_din <= {2'b11, {ADDR_SIZE{1'b0}}};
                    end
                    state <= DATA;
                end

                DATA: begin
                    if (we_q) begin
                        p0_done <= ~winner;
                        p1_done <= winner;
                        state   <= DONE;
                    end else begin
                        rd_cnt <= 8'h00;
                        state  <= WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        rdata   <= ram_dout;
                        p0_done <= ~winner;
                        p1_done <= winner;
                        state   <= DONE;
                    end else if (rd_cnt == 8'(RD_TIMEOUT - 1)) begin
                        rdata   <= 8'h00;
                        err     <= 1'b1;
                        p0_done <= ~winner;
                        p1_done <= winner;
                        state   <= DONE;
                    end else begin
                        rd_cnt <= rd_cnt + 8'h01;
                    end
                end

                DONE: begin
                    // Hand priority to the other port so a re-request
                    // from the same port cannot starve a waiting peer.
                    err    <= 1'b0;
                    rr_ptr <= ~winner;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // addr_q is kept as the frozen copy of the transaction address; the
    // address frame itself is issued straight from the IDLE selection.
    logic unused_addr;
    assign unused_addr = ^addr_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;

    localparam int RD_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_req, p0_we, p0_gnt, p0_done;
    logic [7:0] p0_addr, p0_wdata;
    logic       p1_req, p1_we, p1_gnt, p1_done;
    logic [7:0] p1_addr, p1_wdata;
    logic [7:0] rdata;
    logic       err;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int gnt_cyc[$];
    int gnt_port[$];

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done),
        .rdata(rdata), .err(err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    // Framed single-port RAM: address frames set the pointer, write-data
    // frames store, read-data frames answer one cycle later.
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ram_ptr = 8'h00;
    bit         ram_stuck = 1'b0;

    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00, 2'b10: ram_ptr <= ram_din[7:0];
                2'b01:        mem[ram_ptr] <= ram_din[7:0];
                default: begin
                    if (!ram_stuck) begin
                        ram_dout     <= mem[ram_ptr];
                        ram_tx_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit port, input bit req, input bit we,
                           input logic [7:0] a, input logic [7:0] d);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end else begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end
    endtask

    // One transaction from a single port; cycle 1 is the cycle after the
    // edge that samples req in IDLE.
    task automatic do_txn(input string tag, input bit port, input bit we,
                          input logic [7:0] a, input logic [7:0] d,
                          input int done_cyc, input bit exp_err,
                          input logic [7:0] exp_rd, input bit scramble);
        int cyc;
        bit seen;
        set_req(port, 1'b1, we, a, d);
        @(negedge clk);
        chk({tag, "_gnt"}, port ? p1_gnt : p0_gnt, 1);
        chk({tag, "_frame1"}, {ram_rx_valid, ram_din}, {1'b1, (we ? 2'b00 : 2'b10), a});
        if (scramble) set_req(port, 1'b1, we, a ^ 8'hFF, d ^ 8'hFF);
        @(negedge clk);
        chk({tag, "_gap"}, ram_rx_valid, 0);
        @(negedge clk);
        chk({tag, "_frame2"}, {ram_rx_valid, ram_din},
            we ? {1'b1, 2'b01, d} : {1'b1, 2'b11, 8'h00});
        cyc  = 3;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            seen = port ? p1_done : p0_done;
        end
        chk({tag, "_done_cycle"}, cyc, done_cyc);
        chk({tag, "_err"}, err, exp_err);
        if (!we) chk({tag, "_rdata"}, rdata, exp_rd);
        set_req(port, 1'b0, we, a, d);
        @(negedge clk);
    endtask

    // Both ports request together and hold until ndone completions.
    task automatic both_run(input string tag, input int ndone,
                            input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                            input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                            input logic [7:0] exp_rd1);
        int cyc;
        int dones;
        cyc   = 0;
        dones = 0;
        gnt_cyc.delete();
        gnt_port.delete();
        set_req(1'b0, 1'b1, w0, a0, d0);
        set_req(1'b1, 1'b1, w1, a1, d1);
        while (dones < ndone && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (p0_gnt) begin gnt_cyc.push_back(cyc); gnt_port.push_back(0); end
            if (p1_gnt) begin gnt_cyc.push_back(cyc); gnt_port.push_back(1); end
            if (p0_done) begin
                dones++;
                chk({tag, "_p0_err"}, err, 0);
            end
            if (p1_done) begin
                dones++;
                chk({tag, "_p1_err"}, err, 0);
                if (!w1) chk({tag, "_p1_rdata"}, rdata, exp_rd1);
            end
        end
        set_req(1'b0, 1'b0, w0, a0, d0);
        set_req(1'b1, 1'b0, w1, a1, d1);
        @(negedge clk);
        chk({tag, "_ndone"}, dones, ndone);
    endtask

    initial begin
        int exp3_cyc[4];
        int exp5_cyc[2];
        exp3_cyc = '{1, 6, 12, 17};
        exp5_cyc = '{1, 6};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
        chk("rst_done", {p0_done, p1_done}, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_valid", ram_rx_valid, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;

        // Basic write then read-back from the other port.
        do_txn("t1_p0_wr", 1'b0, 1'b1, 8'h05, 8'hBB, 4, 1'b0, 8'h00, 1'b0);
        do_txn("t2_p1_rd", 1'b1, 1'b0, 8'h05, 8'h00, 5, 1'b0, 8'hBB, 1'b0);

        // Simultaneous requests after reset: p0 first, then strict alternation.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        both_run("t3", 4, 1'b1, 8'h06, 8'hCC, 1'b0, 8'h06, 8'h00, 8'hCC);
        chk("t3_ngnt", gnt_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_gnt%0d_cycle", i), gnt_cyc[i], exp3_cyc[i]);
            chk($sformatf("t3_gnt%0d_port", i), gnt_port[i], i % 2);
        end

        // Read timeout, then a clean transaction with err low.
        ram_stuck = 1'b1;
        do_txn("t4_timeout", 1'b0, 1'b0, 8'h10, 8'h00, 4 + RD_TIMEOUT, 1'b1, 8'h00, 1'b0);
        ram_stuck = 1'b0;
        do_txn("t4_next", 1'b0, 1'b1, 8'h30, 8'h44, 4, 1'b0, 8'h00, 1'b0);

        // Reset during GAP of a p1 write aborts it without a done.
        set_req(1'b1, 1'b1, 1'b1, 8'h05, 8'hCC);
        @(negedge clk);
        chk("t5_gnt", p1_gnt, 1);
        @(negedge clk);
        chk("t5_gap", ram_rx_valid, 0);
        rst = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 8'h05, 8'hCC);
        @(negedge clk);
        chk("t5_rx_valid_after_rst", ram_rx_valid, 0);
        chk("t5_din_after_rst", ram_din, 0);
        chk("t5_no_done", p1_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_idle%0d_done", i), {p0_done, p1_done}, 0);
        end
        // Pointer back at p0: tie goes to p0, then the re-issued p1 write.
        both_run("t5", 2, 1'b1, 8'h20, 8'h11, 1'b1, 8'h05, 8'hCC, 8'h00);
        chk("t5_ngnt", gnt_cyc.size(), 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5_gnt%0d_cycle", i), gnt_cyc[i], exp5_cyc[i]);
            chk($sformatf("t5_gnt%0d_port", i), gnt_port[i], i);
        end
        do_txn("t5_rd", 1'b0, 1'b0, 8'h05, 8'h00, 5, 1'b0, 8'hCC, 1'b0);

        // Requester inputs change mid-transaction; frames keep the latched values.
        do_txn("t6_wr", 1'b0, 1'b1, 8'h07, 8'h5A, 4, 1'b0, 8'h00, 1'b1);
        do_txn("t6_rd", 1'b1, 1'b0, 8'h07, 8'h00, 5, 1'b0, 8'h5A, 1'b0);
        do_txn("t6_rd_ff", 1'b1, 1'b0, 8'hF8, 8'h00, 5, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port sync RAM (10-bit framed command interface: din[9:8] = 00 write-addr, 01 write-data, 10 read-addr, 11 read-data).
- Accepts word-level read/write requests from two requesters (port 0: SPI slave side, port 1: local host/debug) and grants them round-robin.
- Expands each request into the RAM's two-frame command sequence and returns read data with a completion pulse.

Parameters:
- ADDR_SIZE, 8, RAM address width; frame payload width; din width is ADDR_SIZE+2.
- RD_TIMEOUT, 8, max cycles in WAIT_RD before aborting a read with error; legal range 2..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- p0_req  in  1  port 0 request; held high until p0_done
- p0_we  in  1  port 0 direction: 1 write, 0 read
- p0_addr  in  ADDR_SIZE  port 0 RAM address
- p0_wdata  in  8  port 0 write data
- p0_gnt  out  1  one-cycle pulse: port 0 transaction accepted
- p0_done  out  1  one-cycle pulse: port 0 transaction complete
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done: same as port 0, for port 1
- rdata  out  8  read result; valid while a done pulse is high on a read
- err  out  1  high with done when the read timed out
- ram_din  out  ADDR_SIZE+2  frame to RAM din
- ram_rx_valid  out  1  frame strobe to RAM
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-data valid

Behaviour:
- All outputs registered.
- Reset (rst high at a rising edge): state IDLE, all gnt/done/err/ram_rx_valid = 0, ram_din = 0, rdata = 8'h00, RR pointer = port 0.
- Reset mid-transaction aborts immediately: no done is issued and rx_valid drops on the next cycle.
- States and transitions:
  - IDLE: if any req, pick winner; latch we/addr/wdata → ADDR.
  - ADDR (1 cycle): ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}, gnt of winner=1 → GAP.
  - GAP (1 cycle): ram_rx_valid=0 → DATA.
  - DATA (1 cycle): ram_rx_valid=1, ram_din = write ? {2'b01, wdata} : {2'b11, 8'h00}. Write → DONE; read → WAIT_RD, counter cleared.
  - WAIT_RD: ram_rx_valid=0. If ram_tx_valid, capture ram_dout into rdata → DONE. Else if counter == RD_TIMEOUT-1, set rdata=8'h00, err=1 → DONE. Else increment counter.
  - DONE (1 cycle): winner's done=1, err as set; flip RR pointer to the other port → IDLE. err clears on leaving DONE.
- Arbitration:
  - Only one requesting port: it wins.
  - Both requesting: the port named by the RR pointer wins.
  - Pointer changes only in DONE.
  - A port re-requesting immediately after its done loses to a waiting other port.
- Latency, with req sampled in IDLE at edge 0:
  - gnt is high in cycle 1.
  - Write done is high in cycle 4.
  - Read: RAM answers one cycle after the read-data frame, so done is high in cycle 5 with rdata valid. Minimum IDLE gap between transactions: 1 cycle.
- Latched request fields are frozen from IDLE exit to DONE. Requester input changes, or req deassertion, during a transaction are ignored; the transaction completes.
- ram_tx_valid outside WAIT_RD is ignored.
- Address wraps naturally at 2^ADDR_SIZE; there is no range checking.

Test Plan:
- P0 write addr 0x05 data 0xBB → ram_din 10'h005 (rx_valid, cycle 1), 10'h1BB (cycle 3); p0_done in cycle 4; err=0.
- P1 read addr 0x05 after the write above → frames 10'h205 then 10'h300; p1_done in cycle 5 with rdata=0xBB.
- p0 and p1 requests asserted in the same cycle after reset (p0 writes 0x06←0xCC, p1 reads 0x06) → p0 is granted first, then p1; p1 rdata=0xCC. Both held continuously, grants alternate p0,p1,p0,p1.
- RAM model with tx_valid stuck low, p0 read 0x10 → p0_done exactly RD_TIMEOUT cycles after entering WAIT_RD, err=1, rdata=0x00. The next transaction has err=0.
- rst asserted during GAP of a p1 write → no p1_done, ram_rx_valid=0 next cycle, RR pointer=p0. The subsequent p1 write 0x05←0xCC is re-issued, completes normally, and a read of 0x05 returns 0xCC.
- p0_addr and p0_wdata changed during DATA of a p0 write 0x07←0x5A → RAM frames still carry 0x07/0x5A.
